// File: rtl/inv_first_round.sv
// ---------------------------------------------------------------------------
// inv_first_round -- first round of the AES-128 inverse cipher.
//
// Datapath: AddRoundKey (round key 10) -> InvShiftRows -> InvSubBytes, split
// across a two-stage registered pipeline with valid/ready on both sides.
//   Stage 1 registers InvShiftRows(data_in ^ key_in).
//   Stage 2 registers InvSubBytes of stage 1 (16 inv_sbox leaves).
//
// Ports:
//   clk             in   1    rising-edge clock
//   rst_n           in   1    synchronous active-low reset
//   data_active_in  in   1    input block valid
//   in_ready        out  1    block can be accepted this cycle
//   data_in         in   128  ciphertext / state block
//   key_in          in   128  round key 10, sampled with data_in
//   data_active_out out  1    output block valid
//   out_ready       in   1    downstream accepts output
//   data_out        out  128  state after InvSubBytes
//   blk_count       out  16   output handshake count (only with
//                             INV_FIRST_ROUND_BLKCNT_EN defined)
//
// Parameter CLEAR_IDLE: 1 forces data_out to zero while data_active_out=0;
// 0 lets data_out show the stage-2 register at all times.
//
// Optional build macro: INV_FIRST_ROUND_BLKCNT_EN adds the blk_count port
// and a wrapping 16-bit counter of output handshakes.
//
// Byte k of the state lives at bits [127-8k -: 8], with k = row + 4*col.
// ---------------------------------------------------------------------------

// inv_sbox -- AES inverse S-box for one byte.
//   i_byte in 8 : substituted byte
//   o_byte out 8: InvSubBytes(i_byte)
// Computed rather than tabulated: undo the affine transform, then take the
// multiplicative inverse in GF(2^8) as x^254 (which also maps 0 to 0).
module inv_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        // acc accumulates x^2 * x^4 * ... * x^128 = x^254
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] w_pre;

    // Inverse affine transform with its constant folded in (0x63 -> 0x00).
    assign w_pre  = {i_byte[6:0], i_byte[7]} ^ {i_byte[4:0], i_byte[7:5]}
                  ^ {i_byte[1:0], i_byte[7:2]} ^ 8'h05;
    assign o_byte = gf_inv(w_pre);
endmodule

module inv_first_round #(
    parameter bit CLEAR_IDLE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         data_active_in,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic         data_active_out,
    input  logic         out_ready,
    output logic [127:0] data_out
`ifdef INV_FIRST_ROUND_BLKCNT_EN
    ,
    output logic [15:0]  blk_count
`endif
);
    logic         r_s1_valid;
    logic         r_s2_valid;
    logic [127:0] r_s1_data;
    logic [127:0] r_s2_data;

    logic         w_adv1;
    logic         w_adv2;
    logic [127:0] w_ark;
    logic [127:0] w_isr;
    logic [127:0] w_isb;

    // Ready depends only on registered valids and out_ready.
    assign w_adv2   = !r_s2_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign in_ready = w_adv1;

    assign w_ark = data_in ^ key_in;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            // out(r,c) = in(r,(c-r) mod 4)
            localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);

            assign w_isr[127-8*gi -: 8] = w_ark[127-8*SRC -: 8];

            inv_sbox u_inv_sbox (
                .i_byte (r_s1_data[127-8*gi -: 8]),
                .o_byte (w_isb[127-8*gi -: 8])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s2_data  <= '0;
        end else begin
            if (w_adv1) begin
                r_s1_valid <= data_active_in;
                if (data_active_in) r_s1_data <= w_isr;
            end
            if (w_adv2) begin
                r_s2_valid <= r_s1_valid;
                // Load only real blocks so an idle output keeps the last result.
                if (r_s1_valid) r_s2_data <= w_isb;
            end
        end
    end

    assign data_active_out = r_s2_valid;

    generate
        if (CLEAR_IDLE) begin : g_clear_idle
            assign data_out = r_s2_valid ? r_s2_data : 128'h0;
        end else begin : g_hold_idle
            assign data_out = r_s2_data;
        end
    endgenerate

`ifdef INV_FIRST_ROUND_BLKCNT_EN
    logic [15:0] r_blk_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blk_count <= 16'h0000;
        end else if (r_s2_valid && out_ready) begin
            r_blk_count <= r_blk_count + 16'h0001;   // wraps FFFF -> 0
        end
    end

    assign blk_count = r_blk_count;
`endif
endmodule
